// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, PC increments
// and the compressed-instruction opcode test.
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        ALIGN   = 2'd0,
        BUF     = 2'd1,
        LOAD_HI = 2'd2
    } fetch_state_e;

    localparam int         PC_INC_C = 2;
    localparam int         PC_INC_W = 4;
    localparam logic [1:0] OPC_MASK = 2'b11;

    // A halfword starts a 32-bit instruction only when both low bits are set.
    function automatic logic is_compressed(input logic [15:0] half);
        return (half[1:0] & OPC_MASK) != OPC_MASK;
    endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch from a combinational word memory with a valid/ready output.
// Build option: define FETCH_COMPRESSED_EN to add 16-bit compressed instruction support.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_data,
    output logic [31:0]       instr,
    output logic [31:0]       instr_pc,
    output logic              instr_c,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc
);

    logic [31:0]       pc_q, pc_d;
    logic [31:0]       instr_raw;
    logic              instr_c_raw;
    logic              valid_raw;
    logic [ADDR_W-1:0] word_addr;

    assign word_addr = pc_q[ADDR_W+1:2];

`ifdef FETCH_COMPRESSED_EN
    fetch_state_e state_q, state_d;
    logic [15:0]  hbuf_q, hbuf_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            pc_q    <= {RESET_PC[31:1], 1'b0};
            hbuf_q  <= '0;
            state_q <= RESET_PC[1] ? LOAD_HI : ALIGN;
        end else begin
            pc_q    <= pc_d;
            hbuf_q  <= hbuf_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        state_d     = state_q;
        pc_d        = pc_q;
        hbuf_d      = hbuf_q;
        mem_addr    = word_addr;
        instr_raw   = '0;
        instr_c_raw = 1'b0;
        valid_raw   = 1'b0;

        case (state_q)
            ALIGN: begin
                valid_raw = 1'b1;
                if (is_compressed(mem_data[15:0])) begin
                    instr_raw   = {16'h0, mem_data[15:0]};
                    instr_c_raw = 1'b1;
                    if (instr_ready) begin
                        pc_d    = pc_q + 32'(PC_INC_C);
                        hbuf_d  = mem_data[31:16];
                        state_d = BUF;
                    end
                end else begin
                    instr_raw = mem_data;
                    if (instr_ready) pc_d = pc_q + 32'(PC_INC_W);
                end
            end
            BUF: begin
                valid_raw = 1'b1;
                if (is_compressed(hbuf_q)) begin
                    instr_raw   = {16'h0, hbuf_q};
                    instr_c_raw = 1'b1;
                    if (instr_ready) begin
                        pc_d    = pc_q + 32'(PC_INC_C);
                        state_d = ALIGN;
                    end
                end else begin
                    // Straddling instruction: upper half comes from the next word.
                    mem_addr  = word_addr + ADDR_W'(1);
                    instr_raw = {mem_data[15:0], hbuf_q};
                    if (instr_ready) begin
                        pc_d   = pc_q + 32'(PC_INC_W);
                        hbuf_d = mem_data[31:16];
                    end
                end
            end
            LOAD_HI: begin
                hbuf_d  = mem_data[31:16];
                state_d = BUF;
            end
            default: state_d = ALIGN;
        endcase

        if (redirect_valid) begin
            pc_d    = redirect_pc & ~32'h1;
            hbuf_d  = '0;
            state_d = redirect_pc[1] ? LOAD_HI : ALIGN;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_q <= RESET_PC & ~32'h3;
        else     pc_q <= pc_d;
    end

    always_comb begin
        mem_addr    = word_addr;
        instr_raw   = mem_data;
        instr_c_raw = 1'b0;
        valid_raw   = 1'b1;
        pc_d        = pc_q;
        if (redirect_valid)   pc_d = redirect_pc & ~32'h3;
        else if (instr_ready) pc_d = pc_q + 32'(PC_INC_W);
    end
`endif

    // Reset blanks the presented instruction immediately, not at the next edge.
    assign instr_valid = valid_raw & ~rst;
    assign instr       = rst ? '0 : instr_raw;
    assign instr_c     = instr_c_raw & ~rst;
    assign instr_pc    = pc_q;

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC loaded at reset; bit 0 must be 0.
REQ-002 SHALL have parameter ADDR_W, default 6, giving the instruction-memory word-address width (64 words).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, reset, asynchronous and active-high.
REQ-005 SHALL have port mem_addr, output, ADDR_W bits, word address driven to the instruction memory.
REQ-006 SHALL have port mem_data, input, 32 bits, word returned combinationally by the instruction memory in the same cycle.
REQ-007 SHALL have port instr, output, 32 bits, the instruction; 16-bit instructions are zero-extended.
REQ-008 SHALL have port instr_pc, output, 32 bits, byte address of instr.
REQ-009 SHALL have port instr_c, output, 1 bit, set when instr is a 16-bit compressed instruction (bits[1:0] != 2'b11).
REQ-010 SHALL have port instr_valid, output, 1 bit, instr, instr_pc and instr_c are valid.
REQ-011 SHALL have port instr_ready, input, 1 bit, the downstream accepts instr this cycle.
REQ-012 SHALL have port redirect_valid, input, 1 bit, request to restart fetch at redirect_pc.
REQ-013 SHALL have port redirect_pc, input, 32 bits, redirect target; bit 0 is ignored (treated as 0).

Function
REQ-014 SHALL hold a 32-bit pc, a 16-bit halfword buffer hbuf and a 3-state FSM: ALIGN, BUF, LOAD_HI.
REQ-015 ALIGN (pc[1]=0, hbuf empty) SHALL set mem_addr=pc[ADDR_W+1:2].
REQ-016 In ALIGN, if mem_data[1:0]!=2'b11, the block SHALL present {16'h0,mem_data[15:0]} with instr_c=1; on accept, pc+=2, hbuf<=mem_data[31:16], next state BUF.
REQ-017 In ALIGN, otherwise, the block SHALL present mem_data with instr_c=0; on accept, pc+=4, and the state stays ALIGN.
REQ-018 BUF (pc[1]=1, hbuf holds the halfword at pc), if hbuf[1:0]!=2'b11, SHALL present {16'h0,hbuf} with instr_c=1; on accept, pc+=2, next state ALIGN.
REQ-019 BUF, otherwise (32-bit instruction straddling words), SHALL set mem_addr=pc[ADDR_W+1:2]+1 (modulo 2^ADDR_W) and present {mem_data[15:0],hbuf} with instr_c=0; on accept, pc+=4, hbuf<=mem_data[31:16], and the state stays BUF.
REQ-020 LOAD_HI (pc[1]=1, hbuf empty) SHALL set mem_addr=pc[ADDR_W+1:2] and instr_valid=0; next cycle hbuf<=mem_data[31:16], next state BUF (one bubble).
REQ-021 instr_valid SHALL be 1 in ALIGN and BUF and 0 in LOAD_HI; latency from a state entry to valid output is 0 cycles.
REQ-022 With instr_valid=1 and instr_ready=0, all outputs SHALL stay stable and state, pc and hbuf SHALL not change.
REQ-023 redirect_valid SHALL have priority over accept: next cycle pc={redirect_pc[31:1],1'b0}, hbuf is cleared, and the state becomes ALIGN if redirect_pc[1]=0 or LOAD_HI if redirect_pc[1]=1; the instruction presented in the redirect cycle is discarded even if instr_ready=1.
REQ-024 pc SHALL wrap modulo 2^32; mem_addr SHALL wrap modulo 2^ADDR_W (word 63 to word 0) with no special handling.
REQ-025 mem_addr SHALL be driven combinationally from state and pc only, never from instr_ready or redirect inputs.

Reset
REQ-026 While rst=1, the block SHALL drive instr_valid=0, instr=0, instr_pc=RESET_PC and instr_c=0.
REQ-027 Reset SHALL set pc=RESET_PC and clear hbuf, with state ALIGN if RESET_PC[1]=0 or LOAD_HI otherwise.
REQ-028 Reset asserted mid-operation (including mid-straddle) SHALL discard hbuf and any pending instruction immediately.

Configuration
REQ-029 With macro FETCH_COMPRESSED_EN defined, compressed support SHALL be compiled in as specified above.
REQ-030 Without FETCH_COMPRESSED_EN, the block SHALL have only the ALIGN state and no hbuf; pc[1:0] and redirect_pc[1:0] are forced to 0, every word is presented with instr_c=0, and pc+=4 on accept.

Structure
REQ-031 A shared package SHALL hold the FSM state enum (ALIGN, BUF, LOAD_HI), the constants PC_INC_C=2 and PC_INC_W=4, and the compressed-detect opcode mask 2'b11.
REQ-032 The block SHALL have no sub-module; the memory stays external.

Verification
REQ-033 The bench SHALL cover: word0=32'h0000_2083 after reset, instr_ready=1 -> instr=32'h0000_2083, instr_pc=0, instr_c=0, next instr_pc=4.
REQ-034 The bench SHALL cover: word1=32'h0001_4505 -> instr=32'h0000_4505 at pc 4 (c=1), then 32'h0000_0001 at pc 6 (c=1), then pc 8 in ALIGN.
REQ-035 The bench SHALL cover: word2=32'h2083_4505, word3=32'h1234_0000 -> pc 8 gives 32'h0000_4505 (c=1); pc 10 gives 32'h0000_2083 (c=0) with mem_addr=3; hbuf=16'h1234 and the state is BUF.
REQ-036 The bench SHALL cover: redirect_pc=32'h6 with word1=32'h0001_4505 -> one cycle with instr_valid=0 (LOAD_HI), then instr=32'h0000_0001 at pc 6.
REQ-037 The bench SHALL cover: instr_ready=0 for 3 cycles at pc 4 -> outputs held; then ready=1 -> pc 6 follows with no instruction lost or duplicated.
REQ-038 The bench SHALL cover: pc=32'hFC and word63=32'h0000_2083 -> mem_addr=63 and then mem_addr=0 at pc 32'h100; also rst asserted in BUF -> outputs zero while rst is high, then fetch from RESET_PC.
